// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared widths, FSM encoding and latched-access record for the IF/MEM RAM arbiter
package mem_arbiter_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } arb_state_t;

   // Everything the FSM freezes at grant time so requesters may change or drop inputs mid-access
   typedef struct packed {
      logic              gnt_mem;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } access_t;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates IF fetches and MEM loads/stores onto one single-port RAM
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int WAIT_CYCLES = 1,
   parameter int MAX_MEM_RUN = 3
)
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic              mem_ack,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              stall_if,
   output logic              stall_mem
);

   localparam int WAIT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam int RUN_W  = (MAX_MEM_RUN > 0) ? $clog2(MAX_MEM_RUN + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);
   localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(MAX_MEM_RUN);

   arb_state_t        state;
   arb_state_t        state_nx;
   access_t           cur;
   logic [WAIT_W-1:0] wait_cnt;
   logic [RUN_W-1:0]  mem_run_cnt;
   logic              any_req;
   logic              grant_mem;

   // MEM wins unless it has already taken MAX_MEM_RUN grants in a row while IF was waiting
   function automatic logic pick_mem(input logic if_r, input logic mem_r,
                                     input logic [RUN_W-1:0] run);
      return mem_r && !(if_r && (run == RUN_MAX));
   endfunction

   assign any_req   = if_req | mem_req;
   assign grant_mem = pick_mem(if_req, mem_req, mem_run_cnt);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:   if (any_req) state_nx = ST_ACCESS;
         ST_ACCESS: if (wait_cnt == '0) state_nx = ST_RESP;
         ST_RESP:   state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cur         <= '0;
         wait_cnt    <= '0;
         mem_run_cnt <= '0;
         if_rdata    <= '0;
         mem_rdata   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  cur.gnt_mem <= grant_mem;
                  cur.we      <= grant_mem & mem_we;
                  cur.addr    <= grant_mem ? mem_addr : if_addr;
                  cur.wdata   <= grant_mem ? mem_wdata : '0;
                  wait_cnt    <= WAIT_INIT;
               end
               // With if_req high a non-MEM grant is always an IF grant, which ends the run
               if (!if_req || !grant_mem) begin
                  mem_run_cnt <= '0;
               end else if (mem_run_cnt != RUN_MAX) begin
                  mem_run_cnt <= mem_run_cnt + 1'b1;
               end
            end
            ST_ACCESS: begin
               if (wait_cnt != '0) begin
                  wait_cnt <= wait_cnt - 1'b1;
               end else if (cur.gnt_mem) begin
                  mem_rdata <= ram_rdata;
               end else begin
                  if_rdata <= ram_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      if_ack    = 1'b0;
      mem_ack   = 1'b0;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      case (state)
         ST_ACCESS: begin
            ram_en    = 1'b1;
            ram_addr  = cur.addr;
            ram_we    = cur.we;
            ram_wdata = cur.we ? cur.wdata : '0;
         end
         ST_RESP: begin
            if_ack  = ~cur.gnt_mem;
            mem_ack = cur.gnt_mem;
         end
         default: ;
      endcase
   end

   assign stall_if  = if_req & ~if_ack;
   assign stall_mem = mem_req & ~mem_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter at WAIT_CYCLES=1
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int WAIT = 1;

   typedef struct {
      logic       is_mem;
      logic       chk_data;
      logic [7:0] data;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       if_req, mem_req, mem_we;
   logic [7:0] if_addr, mem_addr, mem_wdata;
   logic       if_ack, mem_ack, ram_en, ram_we, stall_if, stall_mem;
   logic [7:0] if_rdata, mem_rdata, ram_addr, ram_wdata, ram_rdata;
   logic       ram_init;
   logic [7:0] ram_model [256];

   int   checks   = 0;
   int   failures = 0;
   exp_t sb [$];

   always #5 clock = ~clock;

   mem_arbiter #(.WAIT_CYCLES(WAIT), .MAX_MEM_RUN(3)) dut (
      .clock(clock), .reset_n(reset_n),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
   );

   function automatic logic [7:0] init_val(input logic [7:0] a);
      return (a == 8'h10) ? 8'hA5 : (a ^ 8'h5A);
   endfunction

   assign ram_rdata = ram_model[ram_addr];

   always @(posedge clock) begin
      if (ram_init) begin
         for (int i = 0; i < 256; i++) ram_model[i] <= init_val(8'(i));
      end else if (ram_en && ram_we) begin
         ram_model[ram_addr] <= ram_wdata;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic is_mem, input logic chk, input logic [7:0] d);
      exp_t e;
      e.is_mem   = is_mem;
      e.chk_data = chk;
      e.data     = d;
      sb.push_back(e);
   endtask

   // Counts negedges until the wanted ack; lat=-1 means the cycle budget ran out
   task automatic wait_ack(input logic want_mem, output int lat, output int en_cnt,
                           output logic stall_ok);
      lat = 0; en_cnt = 0; stall_ok = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         lat++;
         if (ram_en) en_cnt++;
         if (want_mem ? mem_ack : if_ack) return;
         if (!(want_mem ? stall_mem : stall_if)) stall_ok = 1'b0;
      end
      lat = -1;
   endtask

   always @(negedge clock) begin
      exp_t e;
      if (reset_n) begin
         check("ack_exclusive", 32'(if_ack & mem_ack), 32'd0);
         if (if_ack || mem_ack) begin
            if (sb.size() == 0) begin
               check("unexpected_ack", 32'({if_ack, mem_ack}), 32'd0);
            end else begin
               e = sb.pop_front();
               check("ack_owner_is_mem", 32'(mem_ack), 32'(e.is_mem));
               if (e.chk_data)
                  check("ack_rdata", 32'(e.is_mem ? mem_rdata : if_rdata), 32'(e.data));
            end
         end
      end
   end

   initial begin
      int   lat, en_cnt;
      logic stall_ok;

      reset_n = 1'b0; ram_init = 1'b1;
      if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
      repeat (2) @(negedge clock);
      check("reset_outputs", 32'({if_ack, mem_ack, ram_en, ram_we, ram_addr, ram_wdata}), 32'd0);
      check("reset_rdata", 32'({if_rdata, mem_rdata}), 32'd0);
      ram_init = 1'b0;
      reset_n  = 1'b1;
      @(negedge clock);

      // Lone IF read
      if_req = 1'b1; if_addr = 8'h10;
      push(1'b0, 1'b1, 8'hA5);
      #1 check("lone_stall_at_assert", 32'(stall_if), 32'd1);
      wait_ack(1'b0, lat, en_cnt, stall_ok);
      check("lone_latency", 32'(lat), 32'(WAIT + 2));
      check("lone_ram_en_cycles", 32'(en_cnt), 32'(WAIT + 1));
      check("lone_stall_if", 32'(stall_ok), 32'd1);
      check("lone_stall_clear_at_ack", 32'(stall_if), 32'd0);
      if_req = 1'b0;
      @(negedge clock);

      // Simultaneous requests: MEM store first, then IF
      if_req = 1'b1; if_addr = 8'h11;
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 8'h20; mem_wdata = 8'h3C;
      push(1'b1, 1'b0, 8'h00);
      push(1'b0, 1'b1, init_val(8'h11));
      wait_ack(1'b1, lat, en_cnt, stall_ok);
      check("simul_mem_latency", 32'(lat), 32'(WAIT + 2));
      mem_req = 1'b0; mem_we = 1'b0;
      wait_ack(1'b0, lat, en_cnt, stall_ok);
      check("simul_if_latency", 32'(lat), 32'(WAIT + 3));
      check("simul_stall_if", 32'(stall_ok), 32'd1);
      check("simul_ram20", 32'(ram_model[8'h20]), 32'h3C);
      if_req = 1'b0;
      @(negedge clock);

      // Starvation guard: three MEM loads, then IF, then the pending MEM load
      if_req = 1'b1; if_addr = 8'h12;
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 8'h40;
      for (int i = 0; i < 3; i++) push(1'b1, 1'b1, init_val(8'(8'h40 + i)));
      push(1'b0, 1'b1, init_val(8'h12));
      for (int i = 0; i < 3; i++) begin
         wait_ack(1'b1, lat, en_cnt, stall_ok);
         check("starve_mem_latency", 32'(lat), 32'((i == 0) ? WAIT + 2 : WAIT + 3));
         mem_addr = 8'(8'h41 + i);
      end
      push(1'b1, 1'b1, init_val(8'h43));
      wait_ack(1'b0, lat, en_cnt, stall_ok);
      check("starve_if_fourth_grant", 32'(lat), 32'(WAIT + 3));
      check("starve_stall_if", 32'(stall_ok), 32'd1);
      check("starve_mem_rdata_held", 32'(mem_rdata), 32'(init_val(8'h42)));
      if_req = 1'b0;
      wait_ack(1'b1, lat, en_cnt, stall_ok);
      check("starve_mem_resumes", 32'(lat), 32'(WAIT + 3));
      check("starve_if_rdata_held", 32'(if_rdata), 32'(init_val(8'h12)));
      mem_req = 1'b0;
      @(negedge clock);

      // Reset in the middle of a store to 8'h30
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 8'h30; mem_wdata = 8'hEE;
      @(negedge clock);
      check("rst_in_access", 32'({ram_en, ram_we, ram_addr}), 32'({1'b1, 1'b1, 8'h30}));
      #1 reset_n = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
      #1 check("rst_async_outputs", 32'({if_ack, mem_ack, ram_en, ram_we, ram_addr, ram_wdata}), 32'd0);
      check("rst_async_rdata", 32'({if_rdata, mem_rdata}), 32'd0);
      @(negedge clock);
      check("rst_hold_outputs", 32'({if_ack, mem_ack, ram_en, ram_we, ram_addr, ram_wdata}), 32'd0);
      reset_n = 1'b1;
      repeat (6) begin
         @(negedge clock);
         check("rst_no_access_after", 32'(ram_en), 32'd0);
      end
      check("rst_ram30_unchanged", 32'(ram_model[8'h30]), 32'(init_val(8'h30)));

      // Request dropped during ACCESS
      if_req = 1'b1; if_addr = 8'h13;
      push(1'b0, 1'b1, init_val(8'h13));
      @(negedge clock);
      check("drop_in_access", 32'(ram_en), 32'd1);
      if_req = 1'b0;
      wait_ack(1'b0, lat, en_cnt, stall_ok);
      check("drop_ack_latency", 32'(lat), 32'(WAIT + 1));
      repeat (3) begin
         @(negedge clock);
         check("drop_no_regrant", 32'(ram_en), 32'd0);
      end

      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
